// File: rtl/warp_pkg.sv
// Shared front-end types and constants for the fetch/decode path.
package warp_pkg;
  localparam int unsigned INSTR_WIDTH = 32;
  localparam int unsigned PC_STEP     = 4;
  localparam int unsigned PC_WIDTH    = 32;

  typedef logic [PC_WIDTH-1:0]    pc_t;
  typedef logic [INSTR_WIDTH-1:0] instr_t;
endpackage

// File: rtl/fetch_resp_buffer.sv
// Small circular buffer holding returned instruction words until the FIFO takes them.
// The head word is visible combinationally, so a pop takes effect in the cycle it is asserted.
module fetch_resp_buffer
  import warp_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = INSTR_WIDTH,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign head_data = mem[rd_ptr];

  // Storage is not reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      assert (!(push && !pop && count == CNT_W'(DEPTH)))
        else $error("fetch_resp_buffer overflow");
      assert (!(pop && count == '0))
        else $error("fetch_resp_buffer underflow");
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: walks the PC, issues credit-limited imem reads, buffers in-order responses
// and drains them into instruction_fifo; redirects discard stale in-flight responses.
module instruction_fetch_unit
  import warp_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH      = PC_WIDTH,
  parameter int unsigned          MAX_OUTSTANDING = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   imem_req_valid,
  output logic [ADDR_WIDTH-1:0]  imem_req_addr,
  input  logic                   imem_req_ready,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
  output logic                   fifo_push,
  output logic [INSTR_WIDTH-1:0] fifo_data,
  input  logic                   fifo_full,
  output logic                   fifo_flush,
  output logic [ADDR_WIDTH-1:0]  fetch_pc
);

  localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned INF_W  = CNT_W + 1;
  localparam int unsigned DROP_W = CNT_W + 1;

  logic [CNT_W-1:0]      outstanding;
  logic [CNT_W-1:0]      outstanding_nxt;
  logic [CNT_W-1:0]      buf_count;
  logic [DROP_W-1:0]     drop_cnt;
  logic [DROP_W-1:0]     drop_cnt_nxt;
  logic [ADDR_WIDTH-1:0] fetch_pc_nxt;
  logic                  fifo_flush_nxt;
  logic [INF_W-1:0]      inflight;
  logic                  req_fire;
  logic                  rsp_keep;
  logic                  rsp_drop;
  logic                  buf_push;
  logic [INSTR_WIDTH-1:0] buf_head;

  fetch_resp_buffer #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (INSTR_WIDTH)
  ) u_resp_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (buf_push),
    .push_data (imem_rsp_data),
    .pop       (fifo_push),
    .head_data (buf_head),
    .count     (buf_count)
  );

  // Request credit, response steering and drain handshake.
  always_comb begin
    inflight       = INF_W'(outstanding) + INF_W'(buf_count);
    imem_req_valid = enable && !redirect_valid && (inflight < INF_W'(MAX_OUTSTANDING));
    imem_req_addr  = fetch_pc;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_keep       = imem_rsp_valid && (drop_cnt == '0);
    rsp_drop       = imem_rsp_valid && (drop_cnt != '0);
    buf_push       = rsp_keep && !redirect_valid;
    fifo_push      = (buf_count != '0) && !fifo_full && !redirect_valid;
    fifo_data      = buf_head;
  end

  // Next-state for PC and counters; a redirect overrides everything else.
  always_comb begin
    fetch_pc_nxt    = fetch_pc;
    outstanding_nxt = outstanding;
    drop_cnt_nxt    = drop_cnt;
    fifo_flush_nxt  = 1'b0;
    if (redirect_valid) begin
      fetch_pc_nxt    = redirect_pc & ~ADDR_WIDTH'(3);
      // A response arriving now is discarded either way, so it leaves the drop budget.
      drop_cnt_nxt    = drop_cnt + DROP_W'(outstanding) - DROP_W'(imem_rsp_valid);
      outstanding_nxt = '0;
      fifo_flush_nxt  = 1'b1;
    end else begin
      if (req_fire) fetch_pc_nxt = fetch_pc + ADDR_WIDTH'(PC_STEP);
      outstanding_nxt = outstanding + CNT_W'(req_fire) - CNT_W'(rsp_keep);
      drop_cnt_nxt    = drop_cnt - DROP_W'(rsp_drop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      fifo_flush  <= 1'b0;
    end else begin
      fetch_pc    <= fetch_pc_nxt;
      outstanding <= outstanding_nxt;
      drop_cnt    <= drop_cnt_nxt;
      fifo_flush  <= fifo_flush_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (drop_cnt <= DROP_W'(2 * MAX_OUTSTANDING))
        else $error("instruction_fetch_unit drop_cnt out of range");
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a latency-configurable in-order memory model.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        fifo_push;
  logic [31:0] fifo_data;
  logic        fifo_full;
  logic        fifo_flush;
  logic [31:0] fetch_pc;

  // Narrow-PC instance used for the wrap scenario.
  logic        w_enable;
  logic        w_redirect_valid;
  logic [7:0]  w_redirect_pc;
  logic        w_req_valid;
  logic [7:0]  w_req_addr;
  logic        w_req_ready;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_data;
  logic        w_fifo_push;
  logic [31:0] w_fifo_data;
  logic        w_fifo_full;
  logic        w_fifo_flush;
  logic [7:0]  w_fetch_pc;

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .ADDR_WIDTH      (32),
    .MAX_OUTSTANDING (4),
    .RESET_PC        (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .fifo_push      (fifo_push),
    .fifo_data      (fifo_data),
    .fifo_full      (fifo_full),
    .fifo_flush     (fifo_flush),
    .fetch_pc       (fetch_pc)
  );

  instruction_fetch_unit #(
    .ADDR_WIDTH      (8),
    .MAX_OUTSTANDING (4),
    .RESET_PC        (8'hF8)
  ) dut_w (
    .clk            (clk),
    .rst            (rst),
    .enable         (w_enable),
    .redirect_valid (w_redirect_valid),
    .redirect_pc    (w_redirect_pc),
    .imem_req_valid (w_req_valid),
    .imem_req_addr  (w_req_addr),
    .imem_req_ready (w_req_ready),
    .imem_rsp_valid (w_rsp_valid),
    .imem_rsp_data  (w_rsp_data),
    .fifo_push      (w_fifo_push),
    .fifo_data      (w_fifo_data),
    .fifo_full      (w_fifo_full),
    .fifo_flush     (w_fifo_flush),
    .fetch_pc       (w_fetch_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] acc[$];
  logic [31:0] got[$];
  logic [7:0]  wacc[$];
  int          cyc;
  int          lat;
  int          first_push_cyc;
  int          tests_run;
  int          tests_failed;

  logic        s_req_valid;
  logic        s_push;
  logic        s_flush;
  logic [31:0] s_fetch_pc;

  // One clock: present due response, sample outputs mid-cycle, record traffic, advance.
  task automatic step();
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mq[0].addr ^ 32'hA5A5_0000;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    #1;
    s_req_valid = imem_req_valid;
    s_push      = fifo_push;
    s_flush     = fifo_flush;
    s_fetch_pc  = fetch_pc;
    if (imem_rsp_valid) void'(mq.pop_front());
    if (imem_req_valid && imem_req_ready) begin
      mq.push_back('{addr: imem_req_addr, due: cyc + lat});
      acc.push_back(imem_req_addr);
    end
    if (fifo_push) begin
      if (first_push_cyc < 0) first_push_cyc = cyc;
      got.push_back(fifo_data);
    end
    if (w_req_valid && w_req_ready) wacc.push_back(w_req_addr);
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    enable         = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    fifo_full      = 1'b0;
    imem_req_ready = 1'b1;
    w_enable       = 1'b0;
    mq.delete();
    repeat (3) step();
    rst = 1'b0;
    mq.delete();
    acc.delete();
    got.delete();
    wacc.delete();
    first_push_cyc = -1;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    tests_run++;
    if (s_req_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_req_valid got %b want 0", s_req_valid);
    end
    tests_run++;
    if (s_push !== 1'b0) begin
      tests_failed++; $display("FAIL reset_fifo_push got %b want 0", s_push);
    end
    tests_run++;
    if (s_flush !== 1'b0) begin
      tests_failed++; $display("FAIL reset_fifo_flush got %b want 0", s_flush);
    end
    tests_run++;
    if (s_fetch_pc !== 32'h0) begin
      tests_failed++; $display("FAIL reset_fetch_pc got %h want 00000000", s_fetch_pc);
    end
    repeat (3) step();
    tests_run++;
    if (acc.size() != 0) begin
      tests_failed++; $display("FAIL idle_no_requests got %0d want 0", acc.size());
    end
  endtask

  task automatic test_streaming();
    int c0;
    do_reset();
    lat    = 1;
    enable = 1'b1;
    c0     = cyc;
    repeat (12) step();
    tests_run++;
    if (first_push_cyc - c0 != 2) begin
      tests_failed++; $display("FAIL stream_first_push_latency got %0d want 2", first_push_cyc - c0);
    end
    tests_run++;
    if (got.size() != 10) begin
      tests_failed++; $display("FAIL stream_push_per_cycle got %0d want 10", got.size());
    end
    enable = 1'b0;
    repeat (6) step();
    tests_run++;
    if (got.size() != acc.size()) begin
      tests_failed++; $display("FAIL stream_count got %0d want %0d", got.size(), acc.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      tests_run++;
      if (got[i] !== 32'hA5A5_0000 + 32'(4 * i)) begin
        tests_failed++;
        $display("FAIL stream_word[%0d] got %h want %h", i, got[i], 32'hA5A5_0000 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    lat       = 1;
    fifo_full = 1'b1;
    enable    = 1'b1;
    repeat (20) step();
    tests_run++;
    if (acc.size() != 4) begin
      tests_failed++; $display("FAIL bp_request_count got %0d want 4", acc.size());
    end
    tests_run++;
    if (got.size() != 0) begin
      tests_failed++; $display("FAIL bp_no_push got %0d want 0", got.size());
    end
    tests_run++;
    if (s_fetch_pc !== 32'h10) begin
      tests_failed++; $display("FAIL bp_fetch_pc got %h want 00000010", s_fetch_pc);
    end
    fifo_full = 1'b0;
    repeat (8) step();
    enable = 1'b0;
    repeat (8) step();
    tests_run++;
    if (acc.size() <= 4) begin
      tests_failed++; $display("FAIL bp_resume got %0d requests want >4", acc.size());
    end else if (acc[4] !== 32'h10) begin
      tests_failed++; $display("FAIL bp_resume_addr got %h want 00000010", acc[4]);
    end
    tests_run++;
    if (got.size() != acc.size()) begin
      tests_failed++; $display("FAIL bp_count got %0d want %0d", got.size(), acc.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      tests_run++;
      if (got[i] !== 32'hA5A5_0000 + 32'(4 * i)) begin
        tests_failed++;
        $display("FAIL bp_word[%0d] got %h want %h", i, got[i], 32'hA5A5_0000 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_redirect();
    int mark;
    do_reset();
    lat    = 4;
    enable = 1'b1;
    repeat (3) step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    step();
    tests_run++;
    if (s_req_valid !== 1'b0 || s_push !== 1'b0) begin
      tests_failed++;
      $display("FAIL redir_cycle_quiet got req=%b push=%b want 0 0", s_req_valid, s_push);
    end
    redirect_valid = 1'b0;
    got.delete();
    mark = acc.size();
    step();
    tests_run++;
    if (s_flush !== 1'b1) begin
      tests_failed++; $display("FAIL redir_flush_pulse got %b want 1", s_flush);
    end
    tests_run++;
    if (s_fetch_pc !== 32'h100) begin
      tests_failed++; $display("FAIL redir_fetch_pc got %h want 00000100", s_fetch_pc);
    end
    tests_run++;
    if (s_req_valid !== 1'b1) begin
      tests_failed++; $display("FAIL redir_resume got %b want 1", s_req_valid);
    end
    step();
    tests_run++;
    if (s_flush !== 1'b0) begin
      tests_failed++; $display("FAIL redir_flush_single got %b want 0", s_flush);
    end
    repeat (12) step();
    enable = 1'b0;
    repeat (12) step();
    tests_run++;
    if (got.size() != acc.size() - mark) begin
      tests_failed++; $display("FAIL redir_count got %0d want %0d", got.size(), acc.size() - mark);
    end
    for (int i = 0; i < got.size(); i++) begin
      tests_run++;
      if (got[i] !== 32'hA5A5_0100 + 32'(4 * i)) begin
        tests_failed++;
        $display("FAIL redir_word[%0d] got %h want %h", i, got[i], 32'hA5A5_0100 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_back_to_back();
    int mark;
    do_reset();
    lat    = 5;
    enable = 1'b1;
    repeat (3) step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    step();
    redirect_pc    = 32'h300;
    step();
    redirect_valid = 1'b0;
    got.delete();
    mark = acc.size();
    step();
    tests_run++;
    if (s_flush !== 1'b1 || s_fetch_pc !== 32'h300) begin
      tests_failed++;
      $display("FAIL b2b_last_wins got flush=%b pc=%h want 1 00000300", s_flush, s_fetch_pc);
    end
    repeat (20) step();
    enable = 1'b0;
    repeat (15) step();
    tests_run++;
    if (got.size() == 0 || got.size() != acc.size() - mark) begin
      tests_failed++; $display("FAIL b2b_count got %0d want %0d", got.size(), acc.size() - mark);
    end
    for (int i = 0; i < got.size(); i++) begin
      tests_run++;
      if (got[i] !== 32'hA5A5_0300 + 32'(4 * i)) begin
        tests_failed++;
        $display("FAIL b2b_word[%0d] got %h want %h", i, got[i], 32'hA5A5_0300 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_pc_wrap();
    logic [7:0] exp_addr [4];
    exp_addr[0] = 8'hF8;
    exp_addr[1] = 8'hFC;
    exp_addr[2] = 8'h00;
    exp_addr[3] = 8'h04;
    do_reset();
    w_enable = 1'b1;
    repeat (8) step();
    w_enable = 1'b0;
    tests_run++;
    if (wacc.size() != 4) begin
      tests_failed++; $display("FAIL wrap_request_count got %0d want 4", wacc.size());
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (i >= wacc.size()) begin
        tests_failed++; $display("FAIL wrap_addr[%0d] got none want %h", i, exp_addr[i]);
      end else if (wacc[i] !== exp_addr[i]) begin
        tests_failed++; $display("FAIL wrap_addr[%0d] got %h want %h", i, wacc[i], exp_addr[i]);
      end
    end
  endtask

  initial begin
    tests_run        = 0;
    tests_failed     = 0;
    cyc              = 0;
    lat              = 1;
    first_push_cyc   = -1;
    rst              = 1'b1;
    enable           = 1'b0;
    redirect_valid   = 1'b0;
    redirect_pc      = 32'h0;
    imem_req_ready   = 1'b1;
    imem_rsp_valid   = 1'b0;
    imem_rsp_data    = 32'h0;
    fifo_full        = 1'b0;
    w_enable         = 1'b0;
    w_redirect_valid = 1'b0;
    w_redirect_pc    = 8'h0;
    w_req_ready      = 1'b1;
    w_rsp_valid      = 1'b0;
    w_rsp_data       = 32'h0;
    w_fifo_full      = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect();
    test_back_to_back();
    test_pc_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
